// File: rtl/usb_pkg.sv
// Shared types and constants for the USB CRC5/CRC16 engine.
package usb_pkg;

    typedef logic [7:0] bus8_t;

    typedef enum logic {
        CRC5  = 1'b0,
        CRC16 = 1'b1
    } crc_mode_t;

    localparam logic [15:0] CRC5_POLY      = 16'h0005;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC5_RESIDUAL  = 16'h000C;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    function automatic logic [15:0] crc_mask(crc_mode_t m);
        return (m == CRC16) ? 16'hFFFF : 16'h001F;
    endfunction

    function automatic logic [15:0] crc_poly(crc_mode_t m);
        return (m == CRC16) ? CRC16_POLY : CRC5_POLY;
    endfunction

endpackage

// File: rtl/usb_crc_step.sv
// Folds up to BITS_PER_CLK data bits into the CRC, LSB first,
// skipping any bit whose enable is low.
module usb_crc_step
    import usb_pkg::*;
#(
    parameter int BITS_PER_CLK = 1
) (
    input  logic [15:0]             crc_in,
    input  crc_mode_t               mode,
    input  logic [BITS_PER_CLK-1:0] bits,
    input  logic [BITS_PER_CLK-1:0] en,
    output logic [15:0]             crc_out
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            if (en[i]) begin
                fb = bits[i] ^ ((mode == CRC16) ? c[15] : c[4]);
                c  = ({c[14:0], 1'b0} ^ (fb ? crc_poly(mode) : 16'h0))
                     & crc_mask(mode);
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_crc_engine.sv
// USB CRC5/CRC16 engine, BITS_PER_CLK bits folded per clock.
// Define USB_CRC_CHECK_EN to add the good-residual match output.
module usb_crc_engine
    import usb_pkg::*;
#(
    parameter int BITS_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        mode,
    input  logic [7:0]  data,
    input  logic [2:0]  nbits,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic [15:0] crc,
`ifdef USB_CRC_CHECK_EN
    output logic        match,
`endif
    output logic [15:0] crc_tx
);

    localparam int          B     = BITS_PER_CLK;
    localparam logic [3:0]  BSTEP = 4'(B);

    crc_mode_t      mode_q;
    logic [15:0]    crc_q;
    logic [15:0]    crc_step;
    bus8_t          shreg;
    logic [3:0]     rem;
    logic [3:0]     n_acc;
    logic [B-1:0]   en;
    logic           last;
    logic           accept;

    assign busy   = (rem != 4'd0);
    assign last   = busy && (rem <= BSTEP);
    assign ready  = !busy || last;
    assign accept = valid && ready;
    assign n_acc  = (nbits == 3'd0) ? 4'd8 : {1'b0, nbits};

    // Only the bits still owed by this byte take part in the step.
    always_comb begin
        en = '0;
        for (int i = 0; i < B; i++) begin
            en[i] = (4'(i) < rem);
        end
    end

    usb_crc_step #(
        .BITS_PER_CLK(B)
    ) u_step (
        .crc_in  (crc_q),
        .mode    (mode_q),
        .bits    (shreg[B-1:0]),
        .en      (en),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q  <= crc_mask(CRC5);
            mode_q <= CRC5;
            shreg  <= '0;
            rem    <= '0;
        end else begin
            if (init) begin
                mode_q <= crc_mode_t'(mode);
                crc_q  <= crc_mask(crc_mode_t'(mode));
            end else if (busy) begin
                crc_q <= crc_step;
            end

            // A new byte wins over both the abort and the running shift.
            if (accept) begin
                shreg <= data;
                rem   <= n_acc;
            end else if (init) begin
                rem <= '0;
            end else if (busy) begin
                shreg <= shreg >> B;
                rem   <= rem - (last ? rem : BSTEP);
            end
        end
    end

    assign crc = crc_q;

    always_comb begin
        crc_tx = '0;
        if (mode_q == CRC16) begin
            for (int i = 0; i < 16; i++) begin
                crc_tx[i] = ~crc_q[15-i];
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                crc_tx[i] = ~crc_q[4-i];
            end
        end
    end

`ifdef USB_CRC_CHECK_EN
    assign match = (mode_q == CRC16) ? (crc_q == CRC16_RESIDUAL)
                                     : (crc_q == CRC5_RESIDUAL);
`endif

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench: four engines (1, 2, 4, 8 bits per clock) side by side.
module tb_usb_crc_engine;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       init;
    logic [3:0]       mode;
    logic [3:0]       valid;
    logic [3:0][7:0]  data;
    logic [3:0][2:0]  nbits;
    logic [3:0]       ready;
    logic [3:0]       busy;
    logic [3:0][15:0] crc;
    logic [3:0][15:0] crc_tx;
`ifdef USB_CRC_CHECK_EN
    logic [3:0]       match;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        usb_crc_engine #(
            .BITS_PER_CLK(1 << g)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .init   (init[g]),
            .mode   (mode[g]),
            .data   (data[g]),
            .nbits  (nbits[g]),
            .valid  (valid[g]),
            .ready  (ready[g]),
            .busy   (busy[g]),
            .crc    (crc[g]),
`ifdef USB_CRC_CHECK_EN
            .match  (match[g]),
`endif
            .crc_tx (crc_tx[g])
        );
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_fold(logic [15:0] c, logic m,
                                           logic [7:0] d, int n);
        logic [15:0] poly;
        logic        fb;
        poly = m ? 16'h8005 : 16'h0005;
        for (int i = 0; i < n; i++) begin
            fb = d[i] ^ (m ? c[15] : c[4]);
            c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0);
            if (!m) c = c & 16'h001F;
        end
        return c;
    endfunction

    function automatic logic [15:0] m_tx(logic [15:0] c, logic m);
        logic [15:0] t;
        t = '0;
        if (m) begin
            for (int i = 0; i < 16; i++) t[i] = ~c[15-i];
        end else begin
            for (int i = 0; i < 5; i++) t[i] = ~c[4-i];
        end
        return t;
    endfunction

    function automatic string tg(int g, string s);
        return $sformatf("b%0d %s", 1 << g, s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(int g, logic m);
        init[g] = 1'b1;
        mode[g] = m;
        tick();
        init[g] = 1'b0;
        mode[g] = ~m;
    endtask

    // Offer one byte and return just after the accepting edge (cycle T+1).
    task automatic send(int g, logic [7:0] d, int n);
        int wd;
        data[g]  = d;
        nbits[g] = 3'(n);
        valid[g] = 1'b1;
        wd = 0;
        while (!ready[g] && wd < 40) begin
            tick();
            wd++;
        end
        check(tg(g, "accept timeout"), 32'(wd < 40), 32'd1);
        tick();
        valid[g] = 1'b0;
        data[g]  = 8'hFF;
    endtask

    task automatic wait_idle(int g, output int k);
        k = 0;
        while (busy[g] && k < 40) begin
            k++;
            tick();
        end
    endtask

    task automatic run(int g);
        int          k;
        int          bpc;
        int          idx;
        int          cyc;
        int          last_cyc;
        int          bad;
        logic        acc;
        logic [15:0] exp;
        logic [15:0] tx;
        bpc = 1 << g;

        do_init(g, 1'b1);
        check(tg(g, "empty16 crc"), crc[g], 32'hFFFF);
        check(tg(g, "empty16 tx"), crc_tx[g], 32'h0);
        tick();
        check(tg(g, "mode held"), crc[g], 32'hFFFF);

        do_init(g, 1'b0);
        check(tg(g, "empty5 tx"), crc_tx[g], 32'h0);
        send(g, 8'h15, 8);
        wait_idle(g, k);
        check(tg(g, "tok busy8"), k, 8 / bpc);
        send(g, 8'hF7, 3);
        wait_idle(g, k);
        check(tg(g, "tok busy3"), k, (3 + bpc - 1) / bpc);
        exp = m_fold(m_fold(16'h1F, 1'b0, 8'h15, 8), 1'b0, 8'h07, 3);
        check(tg(g, "tok crc"), crc[g], exp);
        check(tg(g, "tok tx"), crc_tx[g], m_tx(exp, 1'b0));
        send(g, crc_tx[g][7:0], 5);
        wait_idle(g, k);
        check(tg(g, "tok resid"), crc[g], 32'h0C);
`ifdef USB_CRC_CHECK_EN
        check(tg(g, "tok match"), match[g], 32'd1);
`endif

        do_init(g, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(g, 8'(i), 8);
            wait_idle(g, k);
        end
        exp = 16'hFFFF;
        for (int i = 0; i < 4; i++) exp = m_fold(exp, 1'b1, 8'(i), 8);
        check(tg(g, "dat crc"), crc[g], exp);
        tx = crc_tx[g];
        check(tg(g, "dat tx"), tx, m_tx(exp, 1'b1));
        send(g, tx[7:0], 8);
        wait_idle(g, k);
        send(g, tx[15:8], 8);
        wait_idle(g, k);
        check(tg(g, "dat resid"), crc[g], 32'h800D);
`ifdef USB_CRC_CHECK_EN
        check(tg(g, "dat match"), match[g], 32'd1);
`endif

        do_init(g, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(g, (i == 2) ? 8'h06 : 8'(i), 8);
            wait_idle(g, k);
        end
        send(g, tx[7:0], 8);
        wait_idle(g, k);
        send(g, tx[15:8], 8);
        wait_idle(g, k);
        check(tg(g, "flip resid"), 32'(crc[g] == 16'h800D), 32'd0);
`ifdef USB_CRC_CHECK_EN
        check(tg(g, "flip match"), match[g], 32'd0);
`endif

        do_init(g, 1'b1);
        idx = 0;
        cyc = 0;
        last_cyc = 0;
        bad = 0;
        data[g]  = 8'd5;
        nbits[g] = 3'd0;
        valid[g] = 1'b1;
        while (idx < 16 && cyc < 400) begin
            acc = ready[g];
            tick();
            cyc++;
            if (acc) begin
                if (idx > 0 && cyc - last_cyc != 8 / bpc) bad++;
                last_cyc = cyc;
                idx++;
                data[g] = 8'(idx * 37 + 5);
            end
        end
        valid[g] = 1'b0;
        check(tg(g, "tput count"), idx, 16);
        check(tg(g, "tput gaps"), bad, 0);
        wait_idle(g, k);
        exp = 16'hFFFF;
        for (int i = 0; i < 16; i++) exp = m_fold(exp, 1'b1, 8'(i * 37 + 5), 8);
        check(tg(g, "tput crc"), crc[g], exp);

        do_init(g, 1'b0);
        send(g, 8'hA5, 8);
        check(tg(g, "col busy"), busy[g], 32'd1);
        do_init(g, 1'b1);
        check(tg(g, "col abort"), busy[g], 32'd0);
        check(tg(g, "col seed"), crc[g], 32'hFFFF);
        init[g]  = 1'b1;
        mode[g]  = 1'b0;
        valid[g] = 1'b1;
        data[g]  = 8'h3C;
        nbits[g] = 3'd0;
        tick();
        init[g]  = 1'b0;
        valid[g] = 1'b0;
        wait_idle(g, k);
        check(tg(g, "col same"), crc[g], m_fold(16'h1F, 1'b0, 8'h3C, 8));

        do_init(g, 1'b1);
        send(g, 8'hF9, 2);
        wait_idle(g, k);
        check(tg(g, "mask crc"), crc[g], m_fold(16'hFFFF, 1'b1, 8'h01, 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        init  = '0;
        mode  = '0;
        valid = '0;
        data  = '0;
        nbits = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            check(tg(g, "rst crc"), crc[g], 32'h1F);
            check(tg(g, "rst ready"), ready[g], 32'd1);
            check(tg(g, "rst busy"), busy[g], 32'd0);
        end

        fork
            run(0);
            run(1);
            run(2);
            run(3);
        join

        for (int g = 0; g < 4; g++) init[g] = 1'b1;
        mode = '0;
        tick();
        init  = '0;
        data  = {4{8'h5A}};
        nbits = '0;
        valid = 4'hF;
        tick();
        valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check(tg(g, "mid rst crc"), crc[g], 32'h1F);
        end
        tick();
        #2 rst_n = 1'b1;
        repeat (10) tick();
        for (int g = 0; g < 4; g++) begin
            check(tg(g, "post rst crc"), crc[g], 32'h1F);
            check(tg(g, "post rst busy"), busy[g], 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_crc_engine.md
USB_CRC_ENGINE -- requirements
Module: usb_crc_engine

Interface
REQ-001 SHALL have parameter BITS_PER_CLK, default 1, meaning data bits folded into the CRC per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port init  input  1  start a new packet: seed CRC, latch mode.
REQ-005 SHALL have port mode  input  1  0 = CRC5 (x^5+x^2+1), 1 = CRC16 (x^16+x^15+x^2+1); sampled only with init.
REQ-006 SHALL have port data  input  8  data byte, processed LSB first.
REQ-007 SHALL have port nbits  input  3  valid bits in data, counted from bit 0; 0 means 8.
REQ-008 SHALL have port valid  input  1  data/nbits offered.
REQ-009 SHALL have port ready  output  1  byte accepted when valid and ready are both high.
REQ-010 SHALL have port busy  output  1  bits still being folded in.
REQ-011 SHALL have port crc  output  16  raw CRC register; CRC5 in [4:0], [15:5] zero in CRC5 mode.
REQ-012 SHALL have port crc_tx  output  16  complemented, bit-reversed CRC, ready to send LSB first; CRC5 in [4:0].
REQ-013 SHALL have port match  output  1  register equals the mode's good-residual constant (present only with USB_CRC_CHECK_EN).

Function
REQ-014 SHALL update one bit per step as d_in = bit ^ crc[MSB], crc = (crc << 1) ^ (d_in ? POLY : 0), where MSB is bit 4 or 15 by mode.
REQ-015 SHALL process an accepted byte of n bits (n = nbits, 0 -> 8) in k = ceil(n/BITS_PER_CLK) cycles; accepted in cycle T, crc final after the edge ending cycle T+k.
REQ-016 SHALL mask the final partial step so that exactly n bits are folded; unused data bits are ignored.
REQ-017 SHALL drive ready = !busy or (busy and in the last step), giving back-to-back throughput of one byte per k cycles.
REQ-018 SHALL assert busy from cycle T+1 through T+k.
REQ-019 SHALL on init load all ones into the active width, latch mode, and abort any byte in progress (busy low next cycle).
REQ-020 SHALL, when init and an accepted byte coincide, seed first and then process the byte against the fresh seed.
REQ-021 SHALL hold crc unchanged while idle; crc_tx and match SHALL be combinational from the register.
REQ-022 SHALL not allow a mode change without init; mode is ignored at all other times.
REQ-023 SHALL, with no bytes after init, give crc_tx = 0 in both modes.

Reset
REQ-024 SHALL on rst_n low set crc = 16'hFFFF masked to CRC5 width, mode = CRC5, busy = 0, ready = 1, shift state cleared.
REQ-025 SHALL, when reset asserts mid-byte, drop the partial byte; no step completes after reset release without a new accept.

Configuration
REQ-026 SHALL use macro USB_CRC_CHECK_EN: when defined, match is present and compares crc to 5'b01100 (CRC5) or 16'h800D (CRC16).
REQ-027 SHALL, without USB_CRC_CHECK_EN, omit the match port and its comparator entirely; all other behaviour is identical.

Structure
REQ-028 SHALL put crc_mode_t (CRC5, CRC16), the CRC5_POLY/CRC16_POLY constants, and the CRC5_RESIDUAL/CRC16_RESIDUAL constants in usb_pkg, reusing bus8_t.
REQ-029 SHALL implement the combinational BITS_PER_CLK step (with bit-enable mask) as sub-module usb_crc_step, instantiated once.

Verification
REQ-030 SHALL cover reset and empty packets: after rst_n release -> crc=5'h1F, ready=1, busy=0; init mode=1 -> crc=16'hFFFF, crc_tx=0.
REQ-031 SHALL cover a token: init CRC5, byte 0x15 (8 bits) then 0x07 (nbits=3) -> crc_tx equals the bench bitwise model, and busy spans exactly 8/B and ceil(3/B) cycles.
REQ-032 SHALL cover a data packet: init CRC16, bytes 0x00 0x01 0x02 0x03, then both crc_tx bytes low first -> match=1 and crc=16'h800D; flipping any one data bit -> match=0.
REQ-033 SHALL cover throughput: valid held high for 16 bytes with BITS_PER_CLK=1,2,4,8 -> accepts every 8,4,2,1 cycles with no gaps, and the result equals the model.
REQ-034 SHALL cover collisions: init asserted in a busy cycle -> busy low next cycle and crc=all ones; init with valid in the same cycle -> result equals a fresh single-byte CRC.
REQ-035 SHALL cover reset mid-byte: rst_n low during cycle T+2 of a byte -> crc=5'h1F immediately and no further crc change until a new accept.
